// File: rtl/sap1_pkg.sv
// Shared definitions for the output-register reader: FSM encoding, digit
// count, seven-segment pattern table and the double-dabble adjust step.
// Latency: n/a (declarations only). Backpressure: n/a.
//
// Contents:
//   state_e     - reader FSM states (IDLE, CONVERT, UPDATE)
//   NUM_DIGITS  - number of decimal digits shown (units, tens, hundreds)
//   BCD_W       - width of the packed BCD accumulator / display register
//   SEG_TABLE   - segment patterns {g,f,e,d,c,b,a} for digits 0..9
//   dabble_adj  - "add 3 to every nibble >= 5" step of double-dabble
package sap1_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Entry [d] is the active-high pattern for decimal digit d, bit order
  // {g,f,e,d,c,b,a}. Listed from digit 9 down to digit 0.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // Pre-shift correction of double-dabble: any BCD nibble that is 5 or more
  // would exceed 9 after doubling, so bias it by 3 to carry correctly.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/leitor_saida_if.sv
// Signal bundle for the reader: read strobe + value in, status and display
// scan out. Latency: n/a (wires only). Backpressure: none; RD while busy is
// simply dropped by the reader, BUSY tells the producer when to retry.
//
// Signals:
//   rd       - read strobe sampling data_in
//   data_in  - unsigned value from the output register
//   busy     - conversion in progress
//   valid    - one-cycle pulse when the display register updates
//   seg      - segments {g,f,e,d,c,b,a}, active-high
//   an       - one-hot digit select, bit0 = units, bit2 = hundreds
// Modports: master = producer/observer side, slave = reader side.
interface leitor_saida_if #(
  parameter int DATA_SIZE = 8
);

  logic                 rd;
  logic [DATA_SIZE-1:0] data_in;
  logic                 busy;
  logic                 valid;
  logic [6:0]           seg;
  logic [2:0]           an;

  modport master (
    output rd,
    output data_in,
    input  busy,
    input  valid,
    input  seg,
    input  an
  );

  modport slave (
    input  rd,
    input  data_in,
    output busy,
    output valid,
    output seg,
    output an
  );

endinterface

// File: rtl/decod_7seg.sv
// BCD nibble to seven-segment pattern decoder, purely combinational.
// Latency: 0 cycles. Backpressure: none.
//
// Ports:
//   digit - 4-bit BCD nibble
//   seg   - segments {g,f,e,d,c,b,a}, active-high; all off for nibbles > 9
module decod_7seg
  import sap1_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    // Codes 10..15 are not decimal digits; leave the display dark for them.
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/leitor_saida.sv
// Output-register reader: converts a sampled binary value to 3 BCD digits by
// double-dabble and drives a multiplexed 3-digit seven-segment display.
// Latency: RD sampled at edge n -> display register and VALID at edge
// n+DATA_SIZE+1. Backpressure: RD is dropped while BUSY (no queueing).
//
// Parameters:
//   DATA_SIZE   - width of DATA_IN, 4..9 (9 bits still fits in 3 digits)
//   REFRESH_DIV - CK cycles each digit stays selected, minimum 2
// Ports:
//   CK      - clock, rising edge
//   MR      - asynchronous active-low reset
//   RD      - read strobe, sampled in IDLE only
//   DATA_IN - unsigned value to convert
//   BUSY    - high in CONVERT and UPDATE
//   VALID   - one-cycle pulse coincident with the display register update
//   SEG     - segments {g,f,e,d,c,b,a}, active-high
//   AN      - one-hot digit select, bit0 = units, bit2 = hundreds
// Build option: define LEITOR_SAIDA_BLANK_EN to blank leading zeros on the
// hundreds and tens digits. The digit scan itself is unaffected.
module leitor_saida
  import sap1_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int REFRESH_DIV = 16
) (
  input  logic                 CK,
  input  logic                 MR,
  input  logic                 RD,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 BUSY,
  output logic                 VALID,
  output logic [6:0]           SEG,
  output logic [2:0]           AN
);

  localparam int CNT_W = $clog2(DATA_SIZE);
  localparam int REF_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [DATA_SIZE-1:0]   bin_q,   bin_d;    // binary shift register
  logic [BCD_W-1:0]       bcd_q,   bcd_d;    // BCD accumulator
  logic [CNT_W-1:0]       cnt_q,   cnt_d;    // CONVERT cycle counter
  logic [BCD_W-1:0]       disp_q,  disp_d;   // display register
  logic                   valid_q, valid_d;
  logic [REF_W-1:0]       ref_q,   ref_d;    // refresh divider
  logic [1:0]             idx_q,   idx_d;    // scanned digit index

  always_ff @(posedge CK or negedge MR) begin
    if (!MR) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // RD is only looked at here, so a strobe during CONVERT/UPDATE is
        // dropped and DATA_IN is never resampled mid-conversion.
        if (RD) begin
          bin_d   = DATA_IN;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        // One double-dabble step: correct nibbles, then shift {bcd,bin}
        // left by one so the binary MSB enters the BCD units nibble.
        {bcd_d, bin_d} = {dabble_adj(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        disp_d  = bcd_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY  = (state_q != IDLE);
  assign VALID = valid_q;

  // ---------------------------------------------------------------------
  // Display scan: runs continuously, independent of the FSM, so the old
  // value stays visible while a new conversion is in progress.
  // ---------------------------------------------------------------------
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
  end

  logic [3:0] units, tens, hundreds;
  logic [3:0] cur_digit;
  logic [6:0] cur_seg;
  logic       blank;

  assign units    = disp_q[3:0];
  assign tens     = disp_q[7:4];
  assign hundreds = disp_q[11:8];

  always_comb begin
    cur_digit = units;
    unique case (idx_q)
      2'd0:    cur_digit = units;
      2'd1:    cur_digit = tens;
      default: cur_digit = hundreds;
    endcase
  end

  decod_7seg u_decod (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

`ifdef LEITOR_SAIDA_BLANK_EN
  // Leading-zero suppression: hundreds dark when 0, tens dark when both
  // hundreds and tens are 0. Units always lit so a zero value shows "0".
  always_comb begin
    blank = 1'b0;
    if (idx_q == 2'd2 && hundreds == 4'd0) begin
      blank = 1'b1;
    end
    if (idx_q == 2'd1 && hundreds == 4'd0 && tens == 4'd0) begin
      blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign SEG = blank ? 7'h00 : cur_seg;
  assign AN  = 3'b001 << idx_q;

endmodule

// File: tb/tb_leitor_saida.sv
// Self-checking bench for leitor_saida (DATA_SIZE=8, REFRESH_DIV=4).
// Accepted reads push {value, expected VALID cycle} to a scoreboard; the
// monitor pops on every VALID and checks timing and the displayed digit.
module tb_leitor_saida;

  localparam int DS   = 8;
  localparam int RDIV = 4;

  logic CK = 1'b0;
  logic MR;

  leitor_saida_if #(.DATA_SIZE(DS)) bus ();

  leitor_saida #(
    .DATA_SIZE   (DS),
    .REFRESH_DIV (RDIV)
  ) dut (
    .CK      (CK),
    .MR      (MR),
    .RD      (bus.rd),
    .DATA_IN (bus.data_in),
    .BUSY    (bus.busy),
    .VALID   (bus.valid),
    .SEG     (bus.seg),
    .AN      (bus.an)
  );

  always #5 CK = ~CK;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int n_valid = 0;
  int last_vcyc = -1;
  int prev_vcyc = -1;
  int last_acc  = -1000;

  typedef struct {
    int val;
    int vcyc;
  } exp_t;

  exp_t sb_q[$];

  always @(posedge CK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'h3F;
      1: pat = 7'h06;
      2: pat = 7'h5B;
      3: pat = 7'h4F;
      4: pat = 7'h66;
      5: pat = 7'h6D;
      6: pat = 7'h7D;
      7: pat = 7'h07;
      8: pat = 7'h7F;
      9: pat = 7'h6F;
      default: pat = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    exp_seg = 'x;
    case (idx)
      0: exp_seg = pat(u);
      1: exp_seg = pat(t);
      2: exp_seg = pat(h);
      default: exp_seg = 'x;
    endcase
`ifdef LEITOR_SAIDA_BLANK_EN
    if (idx == 2 && h == 0) exp_seg = 7'h00;
    if (idx == 1 && h == 0 && t == 0) exp_seg = 7'h00;
`endif
  endfunction

  function automatic int an_idx(input logic [2:0] an);
    case (an)
      3'b001:  an_idx = 0;
      3'b010:  an_idx = 1;
      3'b100:  an_idx = 2;
      default: an_idx = 3;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Called at #1 after an edge; the next edge samples RD.
  task automatic do_rd(input int v);
    int   edge_n;
    logic [31:0] vv;
    vv = v;
    bus.rd      = 1'b1;
    bus.data_in = vv[DS-1:0];
    edge_n = cyc + 1;
    if (edge_n >= last_acc + DS + 2) begin
      last_acc = edge_n;
      sb_q.push_back('{v, edge_n + DS + 1});
    end
    @(posedge CK);
    #1;
    bus.rd      = 1'b0;
    bus.data_in = DS'($urandom);
  endtask

  task automatic model_reset();
    sb_q.delete();
    last_acc = -1000;
  endtask

  task automatic scan_check(input string tag, input int v);
    logic [6:0] s [3];
    logic [2:0] seen;
    int         i;
    seen = '0;
    for (int k = 0; k < 3 * RDIV; k++) begin
      @(posedge CK);
      #1;
      i = an_idx(bus.an);
      if (i < 3) begin
        s[i]    = bus.seg;
        seen[i] = 1'b1;
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'h7);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_dig%0d", tag, d), 32'(s[d]), 32'(exp_seg(v, d)));
    end
  endtask

  // Scoreboard monitor
  always @(posedge CK) begin
    #1;
    if (bus.valid === 1'b1) begin
      n_valid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (sb_q.size() == 0) begin
        check_eq("valid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("valid_cycle", cyc, e.vcyc);
        check_eq("valid_seg", 32'(bus.seg), 32'(exp_seg(e.val, an_idx(bus.an))));
        check_eq("valid_busy", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    int nv;
    MR          = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;

    // Reset state
    wait_cycles(2);
    check_eq("rst_busy",  32'(bus.busy),  32'd0);
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_an",    32'(bus.an),    32'h1);
    check_eq("rst_seg",   32'(bus.seg),   32'(exp_seg(0, 0)));

    // Free-running scan: 4 cycles per digit, two wraps back to units
    MR = 1'b1;
    check_eq("an_scan_0", 32'(bus.an), 32'h1);
    for (int k = 1; k <= 24; k++) begin
      wait_cycles(1);
      check_eq($sformatf("an_scan_%0d", k), 32'(bus.an), 32'(3'b001 << ((k / 4) % 3)));
    end

    // 255: BUSY for DS+1 cycles, VALID at n+DS+1
    do_rd(255);
    for (int k = 0; k < DS + 1; k++) begin
      check_eq($sformatf("busy_255_%0d", k), 32'(bus.busy), 32'd1);
      wait_cycles(1);
    end
    check_eq("busy_255_end",  32'(bus.busy),  32'd0);
    check_eq("valid_255",     32'(bus.valid), 32'd1);
    scan_check("d255", 255);

    // 7: leading zeros shown or blanked depending on build
    do_rd(7);
    wait_cycles(10);
    scan_check("d7", 7);

    // 100, then 42 three cycles later while busy: 42 dropped
    nv = n_valid;
    do_rd(100);
    wait_cycles(2);
    do_rd(42);
    wait_cycles(10);
    check_eq("single_valid", n_valid - nv, 32'd1);
    scan_check("d100", 100);

    // 200 interrupted by reset in cycle 4 of CONVERT
    nv = n_valid;
    do_rd(200);
    wait_cycles(3);
    MR = 1'b0;
    model_reset();
    #1;
    check_eq("mr_busy",  32'(bus.busy),  32'd0);
    check_eq("mr_valid", 32'(bus.valid), 32'd0);
    check_eq("mr_an",    32'(bus.an),    32'h1);
    wait_cycles(2);
    MR = 1'b1;
    scan_check("d_rst", 0);
    check_eq("no_valid_rst", n_valid - nv, 32'd0);

    // RD on first edge after reset release, then back-to-back reads
    MR = 1'b0;
    model_reset();
    wait_cycles(1);
    MR = 1'b1;
    nv = n_valid;
    do_rd(9);
    wait_cycles(9);
    do_rd(10);
    wait_cycles(10);
    check_eq("b2b_valids", n_valid - nv, 32'd2);
    check_eq("b2b_gap", last_vcyc - prev_vcyc, 32'd10);
    scan_check("d10", 10);

    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
